// File: rtl/pdm_dac_pkg.sv
// Shared constants, state encoding and helpers for the pdm_dac output stage.
package pdm_dac_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ACC_W   = DATA_W + 1;
    localparam int unsigned ATTEN_W = 5;

    typedef enum logic [1:0] {
        S_MUTED     = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_PLAY      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_e;

    localparam logic [ATTEN_W-1:0] ATTEN_MUTE    = 5'd16;
    localparam logic [ATTEN_W-1:0] ATTEN_FULL    = 5'd0;
    localparam logic [DATA_W-1:0]  MIDSCALE_DFLT = 16'h8000;

    // Offset-binary <-> two's complement: both directions are an MSB flip.
    function automatic logic [DATA_W-1:0] flip_msb(input logic [DATA_W-1:0] x);
        return {~x[DATA_W-1], x[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/pdm_dac_sdm1.sv
// First-order sigma-delta modulator: 16-bit phase accumulator whose carry is the bitstream.
module sdm1
    import pdm_dac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] level,
    output logic              pdm_out
);

    logic [ACC_W-1:0] acc;

    // Carry out of the previous sum is discarded before the next add, so acc[16] is the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[DATA_W-1:0]} + {1'b0, level};
        end
    end

    assign pdm_out = acc[ACC_W-1];

endmodule

// File: rtl/pdm_dac.sv
// Audio output stage: sample capture on clk_slow rising edges, mute/unmute ramp, PDM conversion.
module pdm_dac
    import pdm_dac_pkg::*;
#(
    parameter int unsigned       RAMP_DIV = 4,
    parameter logic [DATA_W-1:0] MIDSCALE = MIDSCALE_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_slow,
    input  logic [DATA_W-1:0] din,
    input  logic              en,
    output logic              pdm_out,
    output logic              muted,
    output logic              active,
    output logic [DATA_W-1:0] level
);

    localparam int unsigned      CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic                      clk_slow_q;
    logic                      seen_low;
    logic                      stb;
    logic                      step;
    logic [DATA_W-1:0]         sample_q;
    logic [DATA_W-1:0]         lvl;
    logic signed [DATA_W-1:0]  d_s;
    logic signed [DATA_W-1:0]  s_s;
    logic [ATTEN_W-1:0]        atten;
    logic [ATTEN_W-1:0]        atten_nxt;
    logic [CNT_W-1:0]          ramp_cnt;
    logic [CNT_W-1:0]          ramp_cnt_nxt;
    state_e                    state;
    state_e                    state_nxt;
    logic                      muted_nxt;
    logic                      active_nxt;

    // seen_low blocks a false strobe when clk_slow is already high as reset releases.
    assign stb  = clk_slow & ~clk_slow_q & seen_low;
    assign step = stb && (ramp_cnt == CNT_LAST);

    // Sample capture and the registered modulator input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_slow_q <= 1'b0;
            seen_low   <= 1'b0;
            sample_q   <= MIDSCALE;
            level      <= MIDSCALE;
        end else begin
            clk_slow_q <= clk_slow;
            seen_low   <= seen_low | ~clk_slow;
            if (stb) begin
                sample_q <= din;
            end
            level <= lvl;
        end
    end

    // Ramp state register; status outputs are registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_MUTED;
            atten    <= ATTEN_MUTE;
            ramp_cnt <= '0;
            muted    <= 1'b1;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            atten    <= atten_nxt;
            ramp_cnt <= ramp_cnt_nxt;
            muted    <= muted_nxt;
            active   <= active_nxt;
        end
    end

    // Next-state: a change of en always takes priority over a pending attenuation step.
    always_comb begin
        state_nxt    = state;
        atten_nxt    = atten;
        ramp_cnt_nxt = ramp_cnt;
        case (state)
            S_MUTED: begin
                atten_nxt = ATTEN_MUTE;
                if (en) begin
                    state_nxt    = S_RAMP_UP;
                    ramp_cnt_nxt = '0;
                end
            end
            S_RAMP_UP: begin
                if (!en) begin
                    state_nxt    = S_RAMP_DOWN;
                    ramp_cnt_nxt = '0;
                end else if (atten == ATTEN_FULL) begin
                    state_nxt = S_PLAY;
                end else if (stb) begin
                    if (step) begin
                        ramp_cnt_nxt = '0;
                        atten_nxt    = atten - ATTEN_W'(1);
                        if (atten == ATTEN_W'(1)) begin
                            state_nxt = S_PLAY;
                        end
                    end else begin
                        ramp_cnt_nxt = ramp_cnt + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                atten_nxt = ATTEN_FULL;
                if (!en) begin
                    state_nxt    = S_RAMP_DOWN;
                    ramp_cnt_nxt = '0;
                end
            end
            S_RAMP_DOWN: begin
                if (en) begin
                    state_nxt    = S_RAMP_UP;
                    ramp_cnt_nxt = '0;
                end else if (atten >= ATTEN_MUTE) begin
                    state_nxt = S_MUTED;
                end else if (stb) begin
                    if (step) begin
                        ramp_cnt_nxt = '0;
                        atten_nxt    = atten + ATTEN_W'(1);
                        if (atten == ATTEN_MUTE - ATTEN_W'(1)) begin
                            state_nxt = S_MUTED;
                        end
                    end else begin
                        ramp_cnt_nxt = ramp_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt    = S_MUTED;
                atten_nxt    = ATTEN_MUTE;
                ramp_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs: status flags for the next state and the attenuated level.
    always_comb begin
        muted_nxt  = (state_nxt == S_MUTED);
        active_nxt = (state_nxt == S_PLAY);
        d_s        = signed'(flip_msb(sample_q));
        s_s        = d_s >>> atten;
        lvl        = MIDSCALE;
        if (atten < ATTEN_MUTE) begin
            lvl = flip_msb(s_s);
        end
    end

    sdm1 u_sdm1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (level),
        .pdm_out (pdm_out)
    );

endmodule

// File: tb/tb_pdm_dac.sv
// Directed self-checking bench for pdm_dac (RAMP_DIV=1 and RAMP_DIV=2 instances) and sdm1.
module tb_pdm_dac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_slow;
    logic [15:0] din;
    logic        en1;
    logic        en2;
    logic        pdm1, muted1, active1;
    logic        pdm2, muted2, active2;
    logic [15:0] level1, level2;
    logic        rst_s;
    logic [15:0] lvl_s;
    logic        pdm_s;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_up [16] = '{16'h8000, 16'h8001, 16'h8002, 16'h8004,
                                 16'h8008, 16'h8010, 16'h8020, 16'h8040,
                                 16'h8080, 16'h8100, 16'h8200, 16'h8400,
                                 16'h8800, 16'h9000, 16'hA000, 16'hC000};
    logic [15:0] exp_dn [4]  = '{16'h803F, 16'h801F, 16'h800F, 16'h8007};

    always #5 clk = ~clk;

    pdm_dac #(.RAMP_DIV(1), .MIDSCALE(16'h8000)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_slow(clk_slow), .din(din), .en(en1),
        .pdm_out(pdm1), .muted(muted1), .active(active1), .level(level1)
    );

    pdm_dac #(.RAMP_DIV(2), .MIDSCALE(16'h8000)) dut2 (
        .clk(clk), .rst_n(rst_n), .clk_slow(clk_slow), .din(din), .en(en2),
        .pdm_out(pdm2), .muted(muted2), .active(active2), .level(level2)
    );

    sdm1 u_sdm (.clk(clk), .rst_n(rst_s), .level(lvl_s), .pdm_out(pdm_s));

    // One clk_slow period of 4 clk, entered and left on a falling clk edge.
    task automatic pulse_slow();
        clk_slow = 1'b1;
        repeat (2) @(negedge clk);
        clk_slow = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        din      = 16'($urandom);
        en1      = 1'($urandom_range(0, 1));
        en2      = 1'($urandom_range(0, 1));
        clk_slow = 1'($urandom_range(0, 1));
        rst_n    = 1'b0;
        #1;
        checks++; if (pdm1 !== 1'b0)       begin errors++; $display("FAIL reset pdm_out: got %b expected 0", pdm1); end
        checks++; if (muted1 !== 1'b1)     begin errors++; $display("FAIL reset muted: got %b expected 1", muted1); end
        checks++; if (active1 !== 1'b0)    begin errors++; $display("FAIL reset active: got %b expected 0", active1); end
        checks++; if (level1 !== 16'h8000) begin errors++; $display("FAIL reset level: got %h expected 8000", level1); end
        checks++; if (level2 !== 16'h8000) begin errors++; $display("FAIL reset level dut2: got %h expected 8000", level2); end
        din = 16'h8000; en1 = 1'b0; en2 = 1'b0; clk_slow = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_up();
        din = 16'hC000;
        en1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            pulse_slow();
            checks++;
            if (level1 !== exp_up[k]) begin
                errors++; $display("FAIL ramp_up level step %0d: got %h expected %h", k + 1, level1, exp_up[k]);
            end
            checks++;
            if (active1 !== (k == 15)) begin
                errors++; $display("FAIL ramp_up active step %0d: got %b expected %b", k + 1, active1, (k == 15));
            end
        end
    endtask

    task automatic test_play_pattern();
        logic [15:0] bits;
        int          ones;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bits[i] = pdm1;
        end
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(bits[i]);
        checks++; if (ones != 3) begin errors++; $display("FAIL play ones per 4: got %0d expected 3", ones); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bits[i] !== bits[i + 4]) begin
                errors++; $display("FAIL play period bit %0d: got %b expected %b", i + 4, bits[i + 4], bits[i]);
            end
        end
        // From a cleared accumulator the phase is fixed: 0,1,1,1.
        lvl_s = 16'hC000;
        rst_s = 1'b0;
        #1;
        checks++; if (pdm_s !== 1'b0) begin errors++; $display("FAIL sdm reset: got %b expected 0", pdm_s); end
        @(negedge clk);
        rst_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (pdm_s !== ((i % 4) != 0)) begin
                errors++; $display("FAIL sdm C000 cycle %0d: got %b expected %b", i, pdm_s, ((i % 4) != 0));
            end
        end
        lvl_s = 16'h0000;
        rst_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ones += int'(pdm_s);
        end
        checks++; if (ones != 0) begin errors++; $display("FAIL sdm zero level ones: got %0d expected 0", ones); end
    endtask

    task automatic test_mute_density();
        int ones;
        int bad;
        din  = 16'hFFFF;
        ones = 0;
        bad  = 0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            ones += int'(pdm2);
            if (level2 !== 16'h8000) bad++;
            clk_slow = ((i % 16) < 8);
        end
        clk_slow = 1'b0;
        @(negedge clk);
        checks++; if (ones != 32768) begin errors++; $display("FAIL mute density: got %0d ones expected 32768", ones); end
        checks++; if (bad != 0)      begin errors++; $display("FAIL mute level: got %0d off-midscale cycles expected 0", bad); end
        checks++; if (muted2 !== 1'b1) begin errors++; $display("FAIL mute state: got %b expected 1", muted2); end
    endtask

    task automatic test_ramp_down_reverse();
        din = 16'hFFFF;
        en2 = 1'b1;
        @(negedge clk);
        repeat (16) pulse_slow();
        checks++; if (level2 !== 16'h807F) begin errors++; $display("FAIL ramp2 atten8 level: got %h expected 807F", level2); end
        checks++; if (muted2 !== 1'b0 || active2 !== 1'b0) begin
            errors++; $display("FAIL ramp2 atten8 flags: got muted=%b active=%b expected 0 0", muted2, active2);
        end
        en2 = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            repeat (2) pulse_slow();
            checks++;
            if (level2 !== exp_dn[j]) begin
                errors++; $display("FAIL ramp_down step %0d: got %h expected %h", j + 1, level2, exp_dn[j]);
            end
        end
        pulse_slow();
        checks++; if (level2 !== 16'h8007) begin errors++; $display("FAIL ramp_down half step: got %h expected 8007", level2); end
        en2 = 1'b1;
        pulse_slow();
        checks++; if (level2 !== 16'h8007) begin errors++; $display("FAIL reverse with strobe: got %h expected 8007", level2); end
        repeat (2) pulse_slow();
        checks++; if (level2 !== 16'h800F) begin errors++; $display("FAIL reverse then up: got %h expected 800F", level2); end
        en2 = 1'b0;
        @(negedge clk);
        repeat (9) pulse_slow();
        checks++; if (muted2 !== 1'b0)     begin errors++; $display("FAIL atten15 muted: got %b expected 0", muted2); end
        checks++; if (level2 !== 16'h8000) begin errors++; $display("FAIL atten15 level: got %h expected 8000", level2); end
        pulse_slow();
        checks++; if (muted2 !== 1'b1)     begin errors++; $display("FAIL atten16 muted: got %b expected 1", muted2); end
    endtask

    task automatic test_reset_mid_play();
        checks++; if (active1 !== 1'b1) begin errors++; $display("FAIL pre-reset play: got %b expected 1", active1); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pdm1 !== 1'b0)       begin errors++; $display("FAIL mid reset pdm_out: got %b expected 0", pdm1); end
        checks++; if (muted1 !== 1'b1)     begin errors++; $display("FAIL mid reset muted: got %b expected 1", muted1); end
        checks++; if (active1 !== 1'b0)    begin errors++; $display("FAIL mid reset active: got %b expected 0", active1); end
        checks++; if (level1 !== 16'h8000) begin errors++; $display("FAIL mid reset level: got %h expected 8000", level1); end
        clk_slow = 1'b1;
        din      = 16'h0000;
        en1      = 1'b1;
        en2      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (level1 !== 16'h8000) begin errors++; $display("FAIL no spurious capture: got %h expected 8000", level1); end
        checks++; if (muted1 !== 1'b0 || active1 !== 1'b0) begin
            errors++; $display("FAIL ramp after reset flags: got muted=%b active=%b expected 0 0", muted1, active1);
        end
        clk_slow = 1'b0;
        repeat (2) @(negedge clk);
        pulse_slow();
        checks++; if (level1 !== 16'h7FFF) begin errors++; $display("FAIL first real strobe: got %h expected 7FFF", level1); end
    endtask

    initial begin
        rst_n    = 1'b1;
        rst_s    = 1'b1;
        clk_slow = 1'b0;
        en1      = 1'b0;
        en2      = 1'b0;
        din      = 16'h8000;
        lvl_s    = 16'h0000;
        test_reset();
        test_ramp_up();
        test_play_pattern();
        test_mute_density();
        test_ramp_down_reverse();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
